sram_arbiter: RTL and testbench

Shares the single 16-bit asynchronous SRAM port among several requesters: background fetch, sprite fetch, and the frame/asset loader. Sits between those requesters and the tristate/SRAM I/O layer. Sequences each access as a fixed-length CE/OE/WE cycle, grants one requester at a time, and returns read data or write acknowledgement with a one-cycle ack pulse.

---
 rtl/sram_arb_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/sram_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter.
// Contents: FSM state enum, default SRAM widths, the command latch payload.
package sram_arb_pkg;

    localparam int unsigned SRAM_ADDR_W = 20;
    localparam int unsigned SRAM_DATA_W = 16;
    // Command index field is wide enough for up to 16 requesters.
    localparam int unsigned CMD_IDX_W   = 4;
    // Access-length counter holds ACCESS_CYCLES-1 for ACCESS_CYCLES in 1..15.
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Latched copy of the granted requester's command, frozen for one access.
    typedef struct packed {
        logic [CMD_IDX_W-1:0]   idx;
        logic                   we;
        logic [1:0]             be;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select.
// Ports: req (request vector), ptr (search start index),
//        grant_c (one-hot winner), idx_c (winner index; 0 when no request).
module rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant_c,
    output logic [IDX_W-1:0] idx_c
);

    // Walk the ports starting at ptr; first asserted request wins.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] j;
        grant_c = '0;
        idx_c   = '0;
        found   = 1'b0;
        j       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            j = IDX_W'((32'(ptr) + i) % N);
            if (req[j] && !found) begin
                found      = 1'b1;
                grant_c[j] = 1'b1;
                idx_c      = j;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates one asynchronous 16-bit SRAM port among NUM_REQ requesters and
// sequences each access as SETUP / ACCESS(xACCESS_CYCLES) / HOLD.
// Ports: Clk, Reset_N (async active-low); per-port req/we/be/addr/wdata in,
//        ack (one-cycle pulse) and rdata out; SRAM_ADDR and active-low
//        SRAM_CE_N/OE_N/WE_N/UB_N/LB_N strobes, sram_wdata/sram_dq_oe to the
//        tristate layer, sram_rdata from it. All outputs are registered.
// Option: define SRAM_ARB_DISPLAY_PRIO_EN to give port 0 absolute priority,
//         with ports 1..NUM_REQ-1 round-robin among themselves.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 3,
    parameter int unsigned ADDR_W        = SRAM_ADDR_W,
    parameter int unsigned DATA_W        = SRAM_DATA_W,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic                      Clk,
    input  logic                      Reset_N,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [2*NUM_REQ-1:0]      be,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         SRAM_ADDR,
    output logic                      SRAM_CE_N,
    output logic                      SRAM_OE_N,
    output logic                      SRAM_WE_N,
    output logic                      SRAM_UB_N,
    output logic                      SRAM_LB_N,
    output logic [DATA_W-1:0]         sram_wdata,
    output logic                      sram_dq_oe,
    input  logic [DATA_W-1:0]         sram_rdata
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state_q, state_d;
    cmd_t               cmd_q, cmd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] ack_d;
    logic [DATA_W-1:0]  rdata_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  wdata_d;
    logic               ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d, dq_oe_d;

    logic [NUM_REQ-1:0] rr_req;
    logic [NUM_REQ-1:0] rr_grant;
    logic [IDX_W-1:0]   rr_idx;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;

    // Port 0 is removed from the rotating search when it has fixed priority.
`ifdef SRAM_ARB_DISPLAY_PRIO_EN
    assign rr_req = req & ~NUM_REQ'(1);
`else
    assign rr_req = req;
`endif

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req     (rr_req),
        .ptr     (ptr_q),
        .grant_c (rr_grant),
        .idx_c   (rr_idx)
    );

    // Next state, command latch, pointer and next registered output values.
    always_comb begin
        int unsigned nxt;
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        rdata_d = rdata;
        nxt     = 0;

        win_valid = |rr_grant;
        win_idx   = rr_idx;
`ifdef SRAM_ARB_DISPLAY_PRIO_EN
        if (req[0]) begin
            win_valid = 1'b1;
            win_idx   = '0;
        end
`endif

        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    cmd_d.idx = CMD_IDX_W'(win_idx);
                    for (int i = 0; i < int'(NUM_REQ); i++) begin
                        if (win_idx == IDX_W'(i)) begin
                            cmd_d.we    = we[i];
                            cmd_d.be    = be[2*i +: 2];
                            cmd_d.addr  = SRAM_ADDR_W'(addr[i*ADDR_W +: ADDR_W]);
                            cmd_d.wdata = SRAM_DATA_W'(wdata[i*DATA_W +: DATA_W]);
                        end
                    end
                    nxt = 32'(win_idx) + 1;
`ifdef SRAM_ARB_DISPLAY_PRIO_EN
                    // Pointer rotates over ports 1..NUM_REQ-1 only.
                    if (nxt >= NUM_REQ) nxt = 1;
                    if (!req[0]) ptr_d = IDX_W'(nxt);
`else
                    if (nxt >= NUM_REQ) nxt = 0;
                    ptr_d = IDX_W'(nxt);
`endif
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CNT_W'(ACCESS_CYCLES - 1);
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d                     = HOLD;
                    ack_d[IDX_W'(cmd_q.idx)]    = 1'b1;
                    if (!cmd_q.we) rdata_d      = sram_rdata;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes reflect the state being entered so they leave a flop directly.
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        addr_d  = SRAM_ADDR;
        wdata_d = sram_wdata;
        if (state_d != IDLE) begin
            ce_n_d  = 1'b0;
            ub_n_d  = ~cmd_d.be[1];
            lb_n_d  = ~cmd_d.be[0];
            addr_d  = ADDR_W'(cmd_d.addr);
            dq_oe_d = cmd_d.we;
            if (cmd_d.we) wdata_d = DATA_W'(cmd_d.wdata);
        end
        if (state_d == ACCESS) begin
            oe_n_d = cmd_d.we;
            we_n_d = ~cmd_d.we;
        end
    end

    // State and output registers; reset releases every strobe at once.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            ack        <= '0;
            rdata      <= '0;
            SRAM_ADDR  <= '0;
            SRAM_CE_N  <= 1'b1;
            SRAM_OE_N  <= 1'b1;
            SRAM_WE_N  <= 1'b1;
            SRAM_UB_N  <= 1'b1;
            SRAM_LB_N  <= 1'b1;
            sram_wdata <= '0;
            sram_dq_oe <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            ack        <= ack_d;
            rdata      <= rdata_d;
            SRAM_ADDR  <= addr_d;
            SRAM_CE_N  <= ce_n_d;
            SRAM_OE_N  <= oe_n_d;
            SRAM_WE_N  <= we_n_d;
            SRAM_UB_N  <= ub_n_d;
            SRAM_LB_N  <= lb_n_d;
            sram_wdata <= wdata_d;
            sram_dq_oe <= dq_oe_d;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural byte-lane SRAM model.
module tb_sram_arbiter;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned ADDR_W  = 20;
    localparam int unsigned DATA_W  = 16;

    logic                      Clk = 1'b0;
    logic                      Reset_N = 1'b0;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ-1:0]        we = '0;
    logic [2*NUM_REQ-1:0]      be = '0;
    logic [NUM_REQ*ADDR_W-1:0] addr = '0;
    logic [NUM_REQ*DATA_W-1:0] wdata = '0;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         SRAM_ADDR;
    logic                      SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
    logic [DATA_W-1:0]         sram_wdata;
    logic                      sram_dq_oe;
    logic [DATA_W-1:0]         sram_rdata;

    sram_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .ACCESS_CYCLES (2)
    ) dut (
        .Clk        (Clk),
        .Reset_N    (Reset_N),
        .req        (req),
        .we         (we),
        .be         (be),
        .addr       (addr),
        .wdata      (wdata),
        .ack        (ack),
        .rdata      (rdata),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_CE_N  (SRAM_CE_N),
        .SRAM_OE_N  (SRAM_OE_N),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_UB_N  (SRAM_UB_N),
        .SRAM_LB_N  (SRAM_LB_N),
        .sram_wdata (sram_wdata),
        .sram_dq_oe (sram_dq_oe),
        .sram_rdata (sram_rdata)
    );

    always #5 Clk = ~Clk;

    // SRAM model: byte-lane write while CE and WE are low; undriven bus writes junk.
    logic [15:0] mem [0:255];
    always @(posedge Clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) begin
            if (!SRAM_UB_N) mem[SRAM_ADDR[7:0]][15:8] <= sram_dq_oe ? sram_wdata[15:8] : 8'hDE;
            if (!SRAM_LB_N) mem[SRAM_ADDR[7:0]][7:0]  <= sram_dq_oe ? sram_wdata[7:0]  : 8'hAD;
        end
    end
    assign sram_rdata = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[7:0]] : 16'h0000;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ack_idx(input logic [NUM_REQ-1:0] a);
        case (a)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 9;
        endcase
    endfunction

    // Results of the most recent single access.
    int          lat, oe_cnt, we_cnt, dq_cnt;
    logic        ub_v, lb_v;
    logic [15:0] rd_v;
    logic [19:0] addr_v;

    // One access on port p from an idle arbiter; checks latency and ack shape.
    task automatic access(input string tag, input int p, input logic w,
                          input logic [1:0] b, input logic [19:0] a, input logic [15:0] d);
        logic got;
        got = 1'b0; lat = 0; oe_cnt = 0; we_cnt = 0; dq_cnt = 0;
        ub_v = 1'b1; lb_v = 1'b1; rd_v = '0; addr_v = '0;
        we[p] = w;
        be[2*p +: 2] = b;
        addr[p*ADDR_W +: ADDR_W] = a;
        wdata[p*DATA_W +: DATA_W] = d;
        req[p] = 1'b1;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge Clk);
            if (!SRAM_OE_N) oe_cnt++;
            if (!SRAM_WE_N) we_cnt++;
            if (sram_dq_oe) dq_cnt++;
            if (!SRAM_CE_N) begin
                ub_v = SRAM_UB_N;
                lb_v = SRAM_LB_N;
                addr_v = SRAM_ADDR;
            end
            if (ack != '0) begin
                got = 1'b1;
                lat = c;
                rd_v = rdata;
                chk({tag, " ack port"}, 32'(ack), 32'(1 << p));
            end
        end
        req[p] = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'd4);
        @(negedge Clk);
        chk({tag, " ack single pulse"}, 32'(ack), 32'd0);
    endtask

    task automatic do_reset();
        Reset_N = 1'b0;
        req = '0;
        @(negedge Clk);
        @(negedge Clk);
        Reset_N = 1'b1;
        @(negedge Clk);
    endtask

    int order [6];
    int acyc  [6];
    int n;
    int w_seen;
    int late_ack;

    initial begin
        // Reset values
        @(negedge Clk);
        #1;
        chk("rst ack", 32'(ack), 32'd0);
        chk("rst rdata", 32'(rdata), 32'd0);
        chk("rst addr", 32'(SRAM_ADDR), 32'd0);
        chk("rst strobes", {27'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 32'h1F);
        chk("rst dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst wdata", 32'(sram_wdata), 32'd0);
        @(negedge Clk);
        Reset_N = 1'b1;
        @(negedge Clk);

        // Full write, then single read on port 1
        access("wr0", 0, 1'b1, 2'b11, 20'h00010, 16'hBEEF);
        chk("wr0 we_n low cycles", 32'(we_cnt), 32'd2);
        chk("wr0 oe_n low cycles", 32'(oe_cnt), 32'd0);
        chk("wr0 dq_oe cycles", 32'(dq_cnt), 32'd4);
        chk("wr0 rdata untouched", 32'(rdata), 32'd0);

        access("rd1", 1, 1'b0, 2'b11, 20'h00010, 16'h0000);
        chk("rd1 rdata", 32'(rd_v), 32'hBEEF);
        chk("rd1 oe_n low cycles", 32'(oe_cnt), 32'd2);
        chk("rd1 we_n low cycles", 32'(we_cnt), 32'd0);
        chk("rd1 dq_oe cycles", 32'(dq_cnt), 32'd0);
        chk("rd1 sram addr", 32'(addr_v), 32'h00010);

        // Write on port 2, read back on port 0
        access("wr2", 2, 1'b1, 2'b11, 20'h00020, 16'h1234);
        chk("wr2 we_n low cycles", 32'(we_cnt), 32'd2);
        chk("wr2 dq_oe cycles", 32'(dq_cnt), 32'd4);
        chk("wr2 rdata holds", 32'(rdata), 32'hBEEF);
        access("rd0", 0, 1'b0, 2'b11, 20'h00020, 16'h0000);
        chk("rd0 rdata", 32'(rd_v), 32'h1234);

        // Lower-byte write over 0x1111
        access("wr1", 1, 1'b1, 2'b11, 20'h00030, 16'h1111);
        access("bw2", 2, 1'b1, 2'b01, 20'h00030, 16'hAB55);
        chk("bw2 ub_n", 32'(ub_v), 32'd1);
        chk("bw2 lb_n", 32'(lb_v), 32'd0);
        access("rdb", 0, 1'b0, 2'b11, 20'h00030, 16'h0000);
        chk("rdb rdata", 32'(rd_v), 32'h1155);

        // be=00 still completes but writes nothing
        access("bz1", 1, 1'b1, 2'b00, 20'h00030, 16'hFFFF);
        chk("bz1 byte strobes", {30'd0, ub_v, lb_v}, 32'h3);
        chk("bz1 we_n low cycles", 32'(we_cnt), 32'd2);
        access("rdz", 2, 1'b0, 2'b11, 20'h00030, 16'h0000);
        chk("rdz rdata", 32'(rd_v), 32'h1155);

        // Arbitration with all ports requesting
        do_reset();
        we = '0;
        be = '1;
        req = 3'b111;
        n = 0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(negedge Clk);
            if (ack != '0) begin
                order[n] = ack_idx(ack);
                acyc[n] = c;
                n++;
            end
        end
        req = '0;
        chk("rr ack count", 32'(n), 32'd6);
        for (int k = 0; k < 6; k++) begin
`ifdef SRAM_ARB_DISPLAY_PRIO_EN
            chk($sformatf("prio grant %0d", k), 32'(order[k]), 32'd0);
`else
            chk($sformatf("rr grant %0d", k), 32'(order[k]), 32'(k % 3));
`endif
        end
        chk("rr throughput", 32'(acyc[1] - acyc[0]), 32'd5);
        @(negedge Clk);
        @(negedge Clk);

`ifdef SRAM_ARB_DISPLAY_PRIO_EN
        req = 3'b110;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge Clk);
            if (ack != '0) begin
                order[n] = ack_idx(ack);
                n++;
            end
        end
        req = '0;
        chk("prio rr count", 32'(n), 32'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("prio rr grant %0d", k), 32'(order[k]), 32'(1 + (k % 2)));
        @(negedge Clk);
        @(negedge Clk);
`endif

        // Reset during the strobe phase of a write on port 1
        we[1] = 1'b1;
        be[3:2] = 2'b11;
        addr[ADDR_W +: ADDR_W] = 20'h00040;
        wdata[DATA_W +: DATA_W] = 16'h5555;
        req[1] = 1'b1;
        w_seen = 0;
        for (int c = 0; c < 10 && w_seen == 0; c++) begin
            @(negedge Clk);
            if (!SRAM_WE_N) w_seen = 1;
        end
        chk("rstw reached access", 32'(w_seen), 32'd1);
        Reset_N = 1'b0;
        #1;
        chk("rstw strobes", {27'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 32'h1F);
        chk("rstw dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rstw ack", 32'(ack), 32'd0);
        req = '0;
        @(negedge Clk);
        @(negedge Clk);
        Reset_N = 1'b1;
        late_ack = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge Clk);
            if (ack != '0) late_ack++;
        end
        chk("rstw no ack", 32'(late_ack), 32'd0);
        chk("rstw idle ce_n", 32'(SRAM_CE_N), 32'd1);

        // Pointer back at 0: port 0 wins a three-way request first
        we = '0;
        req = 3'b111;
        n = 0;
        for (int c = 0; c < 20 && n < 1; c++) begin
            @(negedge Clk);
            if (ack != '0) begin
                order[0] = ack_idx(ack);
                n++;
            end
        end
        req = '0;
        chk("rstw first ack seen", 32'(n), 32'd1);
        chk("rstw ptr reset grant", 32'(order[0]), 32'd0);
        @(negedge Clk);
        @(negedge Clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
